// File: rtl/scarv_integ_axi2sram_if.sv
// AXI4-Lite channel bundle between a bus master and the axi2sram bridge.
interface scarv_integ_axi2sram_if;
  logic        axi_awvalid;
  logic        axi_awready;
  logic [31:0] axi_awaddr;
  logic [2:0]  axi_awprot;
  logic        axi_wvalid;
  logic        axi_wready;
  logic [31:0] axi_wdata;
  logic [3:0]  axi_wstrb;
  logic        axi_bvalid;
  logic        axi_bready;
  logic        axi_arvalid;
  logic        axi_arready;
  logic [31:0] axi_araddr;
  logic [2:0]  axi_arprot;
  logic        axi_rvalid;
  logic        axi_rready;
  logic [31:0] axi_rdata;

  modport master (
    output axi_awvalid, axi_awaddr, axi_awprot, axi_wvalid, axi_wdata, axi_wstrb,
           axi_bready, axi_arvalid, axi_araddr, axi_arprot, axi_rready,
    input  axi_awready, axi_wready, axi_bvalid, axi_arready, axi_rvalid, axi_rdata
  );

  modport slave (
    input  axi_awvalid, axi_awaddr, axi_awprot, axi_wvalid, axi_wdata, axi_wstrb,
           axi_bready, axi_arvalid, axi_araddr, axi_arprot, axi_rready,
    output axi_awready, axi_wready, axi_bvalid, axi_arready, axi_rvalid, axi_rdata
  );
endinterface

// File: rtl/scarv_integ_axi2sram.sv
// AXI4-Lite slave to single-port synchronous SRAM bridge.
// One transaction in flight; writes win over reads when both are pending.
module scarv_integ_axi2sram #(
  parameter int unsigned MEM_ADDR_W = 14
) (
  input  logic                   g_clk,
  input  logic                   g_resetn,
  scarv_integ_axi2sram_if.slave  axi,
  output logic                   ram_cen,
  output logic                   ram_wen,
  output logic [MEM_ADDR_W-1:0]  ram_addr,
  output logic [31:0]            ram_wdata,
  output logic [3:0]             ram_ben,
  input  logic [31:0]            ram_rdata
);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_COLLECT, S_WR_MEM, S_WR_RESP, S_RD_MEM, S_RD_RESP
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_live;
  logic                  r_aw_cap;
  logic                  r_w_cap;
  logic                  r_rd_first;
  logic [MEM_ADDR_W-1:0] r_addr;
  logic [31:0]           r_wdata;
  logic [3:0]            r_wstrb;
  logic [31:0]           r_rdata;

  logic w_wr_accept;
  logic w_aw_hs;
  logic w_w_hs;
  logic w_ar_hs;
  logic w_unused;

  // r_live keeps every ready low while reset is asserted
  assign w_wr_accept     = r_live && ((r_state == S_IDLE) || (r_state == S_WR_COLLECT));
  assign axi.axi_awready = w_wr_accept && !r_aw_cap;
  assign axi.axi_wready  = w_wr_accept && !r_w_cap;
  assign axi.axi_arready = r_live && (r_state == S_IDLE) && !axi.axi_awvalid && !axi.axi_wvalid;

  assign w_aw_hs = axi.axi_awvalid && axi.axi_awready;
  assign w_w_hs  = axi.axi_wvalid  && axi.axi_wready;
  assign w_ar_hs = axi.axi_arvalid && axi.axi_arready;

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) r_state <= S_IDLE;
    else           r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_WR_COLLECT: begin
        if ((r_aw_cap || w_aw_hs) && (r_w_cap || w_w_hs)) w_state_nxt = S_WR_MEM;
        else if (w_aw_hs || w_w_hs)                         w_state_nxt = S_WR_COLLECT;
        else if (w_ar_hs)                                   w_state_nxt = S_RD_MEM;
      end
      S_WR_MEM:  w_state_nxt = S_WR_RESP;
      S_WR_RESP: if (axi.axi_bready) w_state_nxt = S_IDLE;
      S_RD_MEM:  w_state_nxt = S_RD_RESP;
      S_RD_RESP: if (axi.axi_rready) w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // Captured request fields; AW and AR share the address register
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      r_live     <= 1'b0;
      r_aw_cap   <= 1'b0;
      r_w_cap    <= 1'b0;
      r_rd_first <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
      r_rdata    <= '0;
    end else begin
      r_live     <= 1'b1;
      r_rd_first <= (r_state == S_RD_MEM);
      if (w_aw_hs) begin
        r_aw_cap <= 1'b1;
        r_addr   <= axi.axi_awaddr[MEM_ADDR_W+1:2];
      end
      if (w_w_hs) begin
        r_w_cap <= 1'b1;
        r_wdata <= axi.axi_wdata;
        r_wstrb <= axi.axi_wstrb;
      end
      if (w_ar_hs) r_addr <= axi.axi_araddr[MEM_ADDR_W+1:2];
      if (r_state == S_WR_MEM) begin
        r_aw_cap <= 1'b0;
        r_w_cap  <= 1'b0;
      end
      if (r_rd_first) r_rdata <= ram_rdata;
    end
  end

  assign axi.axi_bvalid = (r_state == S_WR_RESP);
  assign axi.axi_rvalid = (r_state == S_RD_RESP);
  // SRAM data arrives in the first response cycle; held copy is used afterwards
  assign axi.axi_rdata  = r_rd_first ? ram_rdata : r_rdata;

  assign ram_cen   = (r_state == S_WR_MEM) || (r_state == S_RD_MEM);
  assign ram_wen   = (r_state == S_WR_MEM);
  assign ram_ben   = (r_state == S_WR_MEM) ? r_wstrb : 4'b0000;
  assign ram_addr  = r_addr;
  assign ram_wdata = r_wdata;

  assign w_unused = ^{axi.axi_awprot, axi.axi_arprot, axi.axi_awaddr, axi.axi_araddr};

endmodule

// File: tb/tb_scarv_integ_axi2sram.sv
// Bench for scarv_integ_axi2sram: directed scenarios plus random traffic
// checked against a word-array memory model.
module tb_scarv_integ_axi2sram;
  localparam int unsigned AW    = 8;
  localparam int unsigned DEPTH = 1 << AW;

  logic          g_clk    = 1'b0;
  logic          g_resetn = 1'b0;
  logic          ram_cen;
  logic          ram_wen;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_wdata;
  logic [3:0]    ram_ben;
  logic [31:0]   ram_rdata;

  logic [31:0] sram    [DEPTH];
  logic [31:0] ref_mem [DEPTH];
  int n_tests = 0;
  int n_fail  = 0;

  scarv_integ_axi2sram_if axi ();

  scarv_integ_axi2sram #(.MEM_ADDR_W(AW)) dut (
    .g_clk     (g_clk),
    .g_resetn  (g_resetn),
    .axi       (axi),
    .ram_cen   (ram_cen),
    .ram_wen   (ram_wen),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_ben   (ram_ben),
    .ram_rdata (ram_rdata)
  );

  always #5 g_clk = ~g_clk;

  // Synchronous SRAM: read data appears the cycle after the enable
  always @(posedge g_clk) begin
    if (ram_cen) begin
      if (ram_wen) begin
        for (int b = 0; b < 4; b++)
          if (ram_ben[b]) sram[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
      end else begin
        ram_rdata <= sram[ram_addr];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [AW-1:0] word_of(input logic [31:0] byte_addr);
    return AW'((byte_addr / 4) % DEPTH);
  endfunction

  // Called at a negedge with the bridge idle; returns at a negedge, idle again.
  // mode 0: AW+W together, 1: W two cycles ahead of AW, 2: AW two cycles ahead of W
  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int mode, input int bdly);
    int cyc;
    bit aw_done, w_done, aw_hs, w_hs;
    logic [AW-1:0] idx;
    idx = word_of(addr);
    axi.axi_awaddr  = addr;
    axi.axi_awprot  = 3'($urandom);
    axi.axi_wdata   = data;
    axi.axi_wstrb   = strb;
    axi.axi_awvalid = (mode != 1);
    axi.axi_wvalid  = (mode != 2);
    cyc = 0; aw_done = 0; w_done = 0;
    while (!(aw_done && w_done) && cyc < 20) begin
      #1;
      check("wr_arready_blocked", 32'(axi.axi_arready), 32'd0);
      check("wr_collect_no_sram", 32'(ram_cen), 32'd0);
      if (w_done && !aw_done) begin
        check("wr_wait_awready", 32'(axi.axi_awready), 32'd1);
        check("wr_wait_wready", 32'(axi.axi_wready), 32'd0);
      end
      if (aw_done && !w_done) begin
        check("wr_wait_awready", 32'(axi.axi_awready), 32'd0);
        check("wr_wait_wready", 32'(axi.axi_wready), 32'd1);
      end
      aw_hs = axi.axi_awvalid && axi.axi_awready;
      w_hs  = axi.axi_wvalid  && axi.axi_wready;
      @(posedge g_clk);
      @(negedge g_clk);
      cyc++;
      if (aw_hs) begin aw_done = 1; axi.axi_awvalid = 1'b0; end
      if (w_hs)  begin w_done  = 1; axi.axi_wvalid  = 1'b0; end
      if (cyc == 2) begin
        if (!aw_done) axi.axi_awvalid = 1'b1;
        if (!w_done)  axi.axi_wvalid  = 1'b1;
      end
    end
    axi.axi_awvalid = 1'b0;
    axi.axi_wvalid  = 1'b0;
    check("wr_accept_cycles", 32'(cyc), (mode == 0) ? 32'd1 : 32'd3);
    check("wr_mem_cen", 32'(ram_cen), 32'd1);
    check("wr_mem_wen", 32'(ram_wen), 32'd1);
    check("wr_mem_addr", 32'(ram_addr), 32'(idx));
    check("wr_mem_wdata", ram_wdata, data);
    check("wr_mem_ben", 32'(ram_ben), 32'(strb));
    check("wr_mem_bvalid_early", 32'(axi.axi_bvalid), 32'd0);
    for (int b = 0; b < 4; b++)
      if (strb[b]) ref_mem[idx][8*b +: 8] = data[8*b +: 8];
    @(negedge g_clk);
    check("wr_bvalid", 32'(axi.axi_bvalid), 32'd1);
    check("wr_resp_cen", 32'(ram_cen), 32'd0);
    repeat (bdly) begin
      @(negedge g_clk);
      check("wr_bvalid_hold", 32'(axi.axi_bvalid), 32'd1);
    end
    axi.axi_bready = 1'b1;
    @(posedge g_clk);
    @(negedge g_clk);
    axi.axi_bready = 1'b0;
    check("wr_bvalid_drop", 32'(axi.axi_bvalid), 32'd0);
  endtask

  task automatic axi_read(input logic [31:0] addr, input int rdly, output logic [31:0] got);
    int cyc;
    bit hs, hs_now;
    logic [AW-1:0] idx;
    logic [31:0] exp;
    idx = word_of(addr);
    exp = ref_mem[idx];
    axi.axi_araddr  = addr;
    axi.axi_arprot  = 3'($urandom);
    axi.axi_arvalid = 1'b1;
    cyc = 0; hs = 0;
    while (!hs && cyc < 20) begin
      #1;
      hs_now = axi.axi_arvalid && axi.axi_arready;
      @(posedge g_clk);
      @(negedge g_clk);
      cyc++;
      if (hs_now) begin hs = 1; axi.axi_arvalid = 1'b0; end
    end
    axi.axi_arvalid = 1'b0;
    check("rd_accept_cycles", 32'(cyc), 32'd1);
    check("rd_mem_cen", 32'(ram_cen), 32'd1);
    check("rd_mem_wen", 32'(ram_wen), 32'd0);
    check("rd_mem_ben", 32'(ram_ben), 32'd0);
    check("rd_mem_addr", 32'(ram_addr), 32'(idx));
    check("rd_mem_rvalid_early", 32'(axi.axi_rvalid), 32'd0);
    @(negedge g_clk);
    check("rd_rvalid", 32'(axi.axi_rvalid), 32'd1);
    check("rd_rdata", axi.axi_rdata, exp);
    got = axi.axi_rdata;
    repeat (rdly) begin
      @(negedge g_clk);
      check("rd_rvalid_hold", 32'(axi.axi_rvalid), 32'd1);
      check("rd_rdata_hold", axi.axi_rdata, exp);
    end
    axi.axi_rready = 1'b1;
    @(posedge g_clk);
    @(negedge g_clk);
    axi.axi_rready = 1'b0;
    check("rd_rvalid_drop", 32'(axi.axi_rvalid), 32'd0);
  endtask

  initial begin
    logic [31:0] got, a, d;
    logic [3:0]  s;
    for (int i = 0; i < int'(DEPTH); i++) begin
      sram[i]    = 32'h0;
      ref_mem[i] = 32'h0;
    end
    ram_rdata       = 32'h0;
    axi.axi_awvalid = 1'b0; axi.axi_awaddr = 32'h0; axi.axi_awprot = 3'h0;
    axi.axi_wvalid  = 1'b0; axi.axi_wdata  = 32'h0; axi.axi_wstrb  = 4'h0;
    axi.axi_bready  = 1'b0;
    axi.axi_arvalid = 1'b0; axi.axi_araddr = 32'h0; axi.axi_arprot = 3'h0;
    axi.axi_rready  = 1'b0;

    repeat (3) @(negedge g_clk);
    check("rst_awready", 32'(axi.axi_awready), 32'd0);
    check("rst_wready", 32'(axi.axi_wready), 32'd0);
    check("rst_arready", 32'(axi.axi_arready), 32'd0);
    check("rst_bvalid", 32'(axi.axi_bvalid), 32'd0);
    check("rst_rvalid", 32'(axi.axi_rvalid), 32'd0);
    check("rst_cen", 32'(ram_cen), 32'd0);
    check("rst_rdata", axi.axi_rdata, 32'd0);
    g_resetn = 1'b1;
    repeat (2) @(negedge g_clk);

    // Directed scenarios
    axi_write(32'h10, 32'hDEADBEEF, 4'hF, 0, 0);
    axi_read(32'h10, 3, got);
    check("rd_after_wr", got, 32'hDEADBEEF);
    axi_write(32'h20, 32'h12345678, 4'hF, 1, 1);
    axi_write(32'h24, 32'hCAFEF00D, 4'hF, 2, 0);

    axi.axi_araddr  = 32'h20;
    axi.axi_arvalid = 1'b1;
    axi_write(32'h30, 32'h0BADF00D, 4'hF, 0, 2);
    #1;
    check("ar_after_wr_ready", 32'(axi.axi_arready), 32'd1);
    axi_read(32'h20, 0, got);
    check("ar_after_wr_data", got, 32'h12345678);

    axi_write(32'h10, 32'h000055AA, 4'h2, 0, 0);
    axi_read(32'h10, 0, got);
    check("strb2_merge", got, 32'hDEAD55EF);
    axi_write(32'h10, 32'hFFFFFFFF, 4'h0, 0, 1);
    axi_read(32'h10, 0, got);
    check("strb0_nochange", got, 32'hDEAD55EF);
    axi_write(32'h80000403, 32'hA5A5A5A5, 4'hF, 0, 0);
    axi_read(32'h0, 0, got);
    check("addr_wrap", got, 32'hA5A5A5A5);

    // Reset while the SRAM read is in progress
    axi.axi_araddr  = 32'h24;
    axi.axi_arvalid = 1'b1;
    @(posedge g_clk);
    @(negedge g_clk);
    axi.axi_arvalid = 1'b0;
    check("rstmid_rd_mem", 32'(ram_cen), 32'd1);
    g_resetn = 1'b0;
    #1;
    check("rstmid_rvalid", 32'(axi.axi_rvalid), 32'd0);
    check("rstmid_cen", 32'(ram_cen), 32'd0);
    check("rstmid_arready", 32'(axi.axi_arready), 32'd0);
    check("rstmid_awready", 32'(axi.axi_awready), 32'd0);
    check("rstmid_rdata", axi.axi_rdata, 32'd0);
    @(negedge g_clk);
    g_resetn = 1'b1;
    repeat (2) @(negedge g_clk);
    check("rstmid_rvalid_after", 32'(axi.axi_rvalid), 32'd0);
    check("rstmid_bvalid_after", 32'(axi.axi_bvalid), 32'd0);
    axi_read(32'h24, 1, got);
    check("rstmid_next_read", got, 32'hCAFEF00D);

    // Random traffic over a small window of words, with arbitrary high address bits
    for (int k = 0; k < 80; k++) begin
      a = $urandom;
      a[9:2] = 8'($urandom_range(0, 15));
      d = $urandom;
      s = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1)
        axi_write(a, d, s, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
      else
        axi_read(a, int'($urandom_range(0, 3)), got);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
